// File: rtl/hazard3_arb_pkg.sv
// Shared definitions for the round-robin grant arbiter: state encoding and
// hold counter width.
package hazard3_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      OWN     = 2'd1,
      HANDOFF = 2'd2
   } arb_state_t;

   localparam int HOLD_CNT_W = 8;

endpackage

// File: rtl/onehot_priority.sv
// LSB-first priority picker: returns the lowest set bit of i_req as a one-hot
// vector, or zero when i_req is zero.
module onehot_priority #(
   parameter int W = 4
) (
   input  logic [W-1:0] i_req,
   output logic [W-1:0] o_gnt
);

   assign o_gnt = i_req & (~i_req + W'(1));

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with level requests, bounded ownership under
// contention (timeout preempt) and fully registered outputs.
module rr_grant_arbiter
   import hazard3_arb_pkg::*;
#(
   parameter int W_REQ    = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [W_REQ-1:0]         req,
   output logic [W_REQ-1:0]         gnt,
   output logic [$clog2(W_REQ)-1:0] gnt_id,
   output logic                     busy,
   output logic                     preempt
);

   localparam int ID_W = $clog2(W_REQ);
   localparam logic [HOLD_CNT_W-1:0] HOLD_MAX = HOLD_CNT_W'(MAX_HOLD - 1);

   arb_state_t             r_state, w_state_nxt;
   logic [W_REQ-1:0]       r_gnt, w_gnt_nxt;
   logic [ID_W-1:0]        r_gnt_id, w_gnt_id_nxt;
   logic [ID_W-1:0]        r_last_id, w_last_id_nxt;
   logic [HOLD_CNT_W-1:0]  r_hold_cnt, w_hold_nxt;
   logic                   r_busy, r_preempt, w_preempt_nxt;
   logic                   r_armed;

   logic [W_REQ-1:0]       w_above_mask, w_masked_req;
   logic [W_REQ-1:0]       w_win_masked, w_win_unmasked, w_win_oh;
   logic [ID_W-1:0]        w_win_id;
   logic                   w_owner_req, w_others, w_do_grant;

   // Requesters strictly above the last winner get first pick.
   always_comb begin
      w_above_mask = '0;
      for (int i = 0; i < W_REQ; i++) begin
         w_above_mask[i] = (i > int'(r_last_id));
      end
   end

   assign w_masked_req = req & w_above_mask;

   onehot_priority #(.W(W_REQ)) u_pri_masked (
      .i_req (w_masked_req),
      .o_gnt (w_win_masked)
   );

   onehot_priority #(.W(W_REQ)) u_pri_unmasked (
      .i_req (req),
      .o_gnt (w_win_unmasked)
   );

   assign w_win_oh = (|w_masked_req) ? w_win_masked : w_win_unmasked;

   always_comb begin
      w_win_id = '0;
      for (int i = 0; i < W_REQ; i++) begin
         if (w_win_oh[i]) w_win_id = w_win_id | ID_W'(i);
      end
   end

   assign w_owner_req = |(req & r_gnt);
   assign w_others    = |(req & ~r_gnt);

   always_comb begin
      w_state_nxt   = r_state;
      w_gnt_nxt     = r_gnt;
      w_gnt_id_nxt  = r_gnt_id;
      w_last_id_nxt = r_last_id;
      w_hold_nxt    = r_hold_cnt;
      w_preempt_nxt = 1'b0;
      w_do_grant    = 1'b0;

      case (r_state)
         IDLE: begin
            if (r_armed && (|req)) w_do_grant = 1'b1;
         end
         OWN: begin
            if (!w_owner_req) begin
               if (|req) begin
                  w_do_grant = 1'b1;
               end else begin
                  w_gnt_nxt   = '0;
                  w_state_nxt = IDLE;
               end
            end else if ((r_hold_cnt == HOLD_MAX) && w_others) begin
               w_gnt_nxt     = '0;
               w_preempt_nxt = 1'b1;
               w_state_nxt   = HANDOFF;
            end else if (r_hold_cnt != HOLD_MAX) begin
               w_hold_nxt = r_hold_cnt + HOLD_CNT_W'(1);
            end
         end
         HANDOFF: begin
            if (|req) w_do_grant = 1'b1;
            else      w_state_nxt = IDLE;
         end
         default: begin
            w_gnt_nxt   = '0;
            w_state_nxt = IDLE;
         end
      endcase

      if (w_do_grant) begin
         w_state_nxt   = OWN;
         w_gnt_nxt     = w_win_oh;
         w_gnt_id_nxt  = w_win_id;
         w_last_id_nxt = w_win_id;
         w_hold_nxt    = '0;
      end
   end

   // r_armed keeps the first edge after reset release grant-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_gnt_id   <= '0;
         r_last_id  <= ID_W'(W_REQ - 1);
         r_hold_cnt <= '0;
         r_busy     <= 1'b0;
         r_preempt  <= 1'b0;
         r_armed    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_gnt      <= w_gnt_nxt;
         r_gnt_id   <= w_gnt_id_nxt;
         r_last_id  <= w_last_id_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_busy     <= |w_gnt_nxt;
         r_preempt  <= w_preempt_nxt;
         r_armed    <= 1'b1;
      end
   end

   assign gnt     = r_gnt;
   assign gnt_id  = r_gnt_id;
   assign busy    = r_busy;
   assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: directed scenarios plus random
// request traffic against an abstract behavioural model.
module tb_rr_grant_arbiter;

   localparam int W  = 4;
   localparam int MH = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] req;
   logic [W-1:0] gnt;
   logic [1:0]   gnt_id;
   logic         busy;
   logic         preempt;

   rr_grant_arbiter #(.W_REQ(W), .MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .busy    (busy),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] g;
      logic [1:0] id;
      logic       b;
      logic       p;
   } obs_t;

   obs_t exp_q[$];
   obs_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: who owns the grant, how long it has held it, who won last.
   int m_owner, m_last, m_id, m_held;
   bit m_handoff, m_armed, m_pre;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      n_checks++;
      if (act !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
      end
   endtask

   function automatic void model_reset();
      m_owner   = -1;
      m_last    = W - 1;
      m_id      = 0;
      m_held    = 0;
      m_handoff = 0;
      m_armed   = 0;
      m_pre     = 0;
   endfunction

   function automatic int pick(input logic [3:0] v);
      for (int i = m_last + 1; i < W; i++) if (v[i]) return i;
      for (int i = 0; i < W; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic void grant(input int w);
      m_owner = w;
      m_last  = w;
      m_id    = w;
      m_held  = 0;
   endfunction

   function automatic void model_eval(input logic [3:0] v);
      m_pre = 0;
      if (!m_armed) begin
         m_armed = 1;
         return;
      end
      if (m_owner < 0) begin
         m_handoff = 0;
         if (v != 0) grant(pick(v));
      end else if (!v[m_owner]) begin
         if (v != 0) grant(pick(v));
         else m_owner = -1;
      end else if (m_held == MH - 1 && (v & ~(4'b0001 << m_owner)) != 0) begin
         m_owner   = -1;
         m_handoff = 1;
         m_pre     = 1;
      end else if (m_held < MH - 1) begin
         m_held++;
      end
   endfunction

   function automatic obs_t model_obs();
      obs_t o;
      o.g  = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      o.id = 2'(m_id);
      o.b  = (m_owner >= 0);
      o.p  = m_pre;
      return o;
   endfunction

   task automatic step(input logic [3:0] v);
      req = v;
      model_eval(v);
      @(posedge clk);
      exp_q.push_back(model_obs());
      #2;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async_gnt", gnt, 0);
      check("rst_async_busy", busy, 0);
      check("rst_async_preempt", preempt, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      model_reset();
   endtask

   // Monitor: invariants every cycle, scoreboard pop when an expectation is pending.
   always @(negedge clk) begin
      check("onehot0_gnt", $onehot0(gnt), 1);
      check("busy_vs_gnt", busy, |gnt);
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("outputs{gnt,id,busy,pre}", {gnt, gnt_id, busy, preempt}, mon_e);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] r;
      int order[$];
      int prev, gaps, pre_cnt, bad;
      int exp_order[5] = '{0, 1, 2, 3, 0};

      rst_n = 1'b0;
      req   = '0;
      model_reset();
      #12;
      check("reset_gnt", gnt, 0);
      check("reset_gnt_id", gnt_id, 0);
      check("reset_busy", busy, 0);
      check("reset_preempt", preempt, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // First edge after release must not grant; then 1-cycle latency, no-gap handover.
      step(4'b0110);
      check("no_grant_first_edge", gnt, 4'b0000);
      step(4'b0110);
      check("first_grant_0110", gnt, 4'b0010);
      step(4'b0100);
      check("handover_no_gap", gnt, 4'b0100);
      step(4'b0000);
      step(4'b0000);

      // All requesting, each owner releasing after 3 cycles of ownership.
      do_reset();
      prev = -1;
      gaps = 0;
      for (int k = 0; k < 20; k++) begin
         r = 4'hF;
         if (m_owner >= 0 && m_held == 2) r[m_owner] = 1'b0;
         step(r);
         if (busy && int'(gnt_id) != prev) begin
            order.push_back(int'(gnt_id));
            prev = int'(gnt_id);
         end
         if (order.size() > 0 && !busy) gaps++;
      end
      check("rr_order_len_ge5", order.size() >= 5, 1);
      for (int i = 0; i < 5; i++) begin
         if (i < order.size()) check("rr_order", order[i], exp_order[i]);
      end
      check("rr_busy_gaps", gaps, 0);

      // Two requesters never releasing: timeout alternation.
      do_reset();
      step(4'b0000);
      pre_cnt = 0;
      bad     = 0;
      for (int k = 1; k <= 20; k++) begin
         step(4'b0011);
         if (preempt) pre_cnt++;
         if (gnt !== ((k % 5 == 0) ? 4'b0000 : ((((k - 1) / 5) % 2 == 0) ? 4'b0001 : 4'b0010)))
            bad++;
         if ((k % 5 == 0) != preempt) bad++;
      end
      check("timeout_pattern_errs", bad, 0);
      check("timeout_preempt_count", pre_cnt, 4);
      step(4'b0000);

      // Sole requester keeps the grant indefinitely.
      pre_cnt = 0;
      bad     = 0;
      for (int k = 0; k < 100; k++) begin
         step(4'b0100);
         if (preempt) pre_cnt++;
         if (gnt !== 4'b0100) bad++;
      end
      check("sole_gnt_errs", bad, 0);
      check("sole_preempt_count", pre_cnt, 0);

      // Reset mid-grant, then first grant goes to requester 0.
      step(4'b0000);
      step(4'b0000);
      step(4'b1000);
      check("pre_reset_gnt", gnt, 4'b1000);
      step(4'b1000);
      do_reset();
      step(4'b1001);
      check("post_reset_no_grant", gnt, 4'b0000);
      step(4'b1001);
      check("post_reset_first_grant", gnt, 4'b0001);

      // Non-owner bit toggling while the owner holds.
      for (int k = 0; k < 12; k++) step((k % 2) ? 4'b0101 : 4'b0001);
      step(4'b0000);
      step(4'b0000);

      // Random level requests with occasional bit flips and one mid-run reset.
      r = '0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 9) < 3) r[$urandom_range(0, W - 1)] ^= 1'b1;
         if (k == 200) do_reset();
         step(r);
      end

      step(4'b0000);
      @(negedge clk);
      #1;
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_grant_arbiter.md
RR_GRANT_ARBITER -- requirements
Module: rr_grant_arbiter

Interface
REQ-001 SHALL have parameter W_REQ, default 4, meaning the number of requesters (2..16).
REQ-002 SHALL have parameter MAX_HOLD, default 16, meaning the maximum contiguous grant cycles while other requests are pending (2..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req, input, W_REQ bits: level requests, held high until the requester is done.
REQ-006 SHALL have port gnt, output, W_REQ bits: registered one-hot grant, or zero.
REQ-007 SHALL have port gnt_id, output, $clog2(W_REQ) bits: binary index of the current owner, valid when busy=1.
REQ-008 SHALL have port busy, output, 1 bit: high when gnt is nonzero.
REQ-009 SHALL have port preempt, output, 1 bit: single-cycle pulse when a grant is revoked by timeout.

Function
REQ-010 SHALL implement states IDLE, OWN and HANDOFF, with all outputs registered.
REQ-011 SHALL, in IDLE with req nonzero, select a winner and move to OWN, with gnt asserted on the next edge (1-cycle request-to-grant latency).
REQ-012 SHALL select round-robin: candidates are req bits strictly above last_id; if any exist, the lowest of them wins, else the lowest set bit of req wins.
REQ-013 SHALL update last_id to the winner at every grant.
REQ-014 SHALL hold gnt unchanged in OWN while req[gnt_id]=1; gnt SHALL never have more than one bit set.
REQ-015 SHALL handle owner release (req[gnt_id]=0 in OWN) as follows: if other requests are present, the next winner is granted on the following edge with no idle cycle; otherwise gnt clears and the state returns to IDLE.
REQ-016 SHALL maintain hold_cnt, 8 bits, cleared at every new grant and incremented each OWN cycle, saturating at MAX_HOLD-1.
REQ-017 SHALL, when hold_cnt=MAX_HOLD-1 and any req bit other than gnt_id is set, clear gnt, pulse preempt for one cycle and enter HANDOFF.
REQ-018 SHALL, in HANDOFF, arbitrate using the rule of REQ-012, so the preempted owner loses to any other requester, then enter OWN; if req is zero it SHALL enter IDLE.
REQ-019 SHALL let a sole requester hold the grant indefinitely; the timeout applies only when there is contention.
REQ-020 SHALL ignore req changes on non-owner bits during OWN except for the timeout check.
REQ-021 SHALL hold gnt_id at its last value when busy=0.

Reset
REQ-022 SHALL, on rst_n low (asynchronous), force state=IDLE, gnt=0, gnt_id=0, busy=0, preempt=0, hold_cnt=0 and last_id=W_REQ-1, so that requester 0 has first priority.
REQ-023 SHALL, on reset asserted mid-grant, drop gnt immediately without waiting for a clock, with no preempt pulse.
REQ-024 SHALL NOT grant on the first edge after reset deassertion; arbitration starts on the second edge.

Structure
REQ-025 SHALL take the state encoding (IDLE=0, OWN=1, HANDOFF=2) from a shared package, hazard3_arb_pkg.
REQ-026 SHALL instantiate the existing onehot_priority (LSB-first) twice, once for masked and once for unmasked requests.
REQ-027 SHALL contain no other sub-modules; the one-hot-to-binary conversion for gnt_id SHALL be inline.

Verification
REQ-028 SHALL cover: after reset, req=4'b0110 -> gnt=4'b0010 one cycle later; on release of req[1], gnt=4'b0100 on the next edge with no gap.
REQ-029 SHALL cover: req=4'b1111 held, each owner dropping its req after 3 cycles -> grant order 0,1,2,3,0 with busy continuously high.
REQ-030 SHALL cover: MAX_HOLD=4, req=4'b0011 never released -> gnt=0001 for 4 cycles, a one-cycle preempt pulse with gnt=0, then gnt=0010 for 4 cycles, alternating.
REQ-031 SHALL cover: only req[2] high for 100 cycles -> gnt=0100 throughout and preempt never asserted.
REQ-032 SHALL cover: rst_n pulsed low while gnt=1000 -> gnt=0 asynchronously, then with req=4'b1001 the first grant after reset is 0001.
REQ-033 SHALL cover: gnt held constant while a non-owner req bit toggles every cycle, with onehot0(gnt) asserted at every cycle of every test.
